mem_arb_unit: RTL and testbench
===============================

MEM_ARB_UNIT -- requirements
Module: mem_arb_unit

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: dAddr  in  32  EX data address; dWData  in  32  EX store data; dLoad  in  1  load request; dStore  in  1  store request; dSize  in  2  0 byte, 1 word, 2 long, 3 reserved; dRegO  in  7  load destination register.
REQ-004 SHALL have ports: dHold  out  1  stall to EX; dRegOutO  out  7  writeback register; dRegOutVal  out  32  writeback value; dRegOutV  out  1  writeback valid; dAlignErr  out  1  request rejected.
REQ-005 SHALL have ports: iAddr  in  32  icache fill address; iOE  in  1  fill request; iData  out  32  fill data; iOK  out  1  fill done.
REQ-006 SHALL have ports: extAddr  out  32; extData  inout  32; extOE  out  1; extWR  out  1; extOK  in  1; busErr  out  1  timeout abort.

Function
REQ-007 SHALL implement states IDLE, DREAD, DWRITE, RMW_RD, RMW_WR, IFILL, DONE.
REQ-008 IDLE SHALL give data request priority over iOE; iOE SHALL be sampled only in IDLE.
REQ-009 Misalignment SHALL be: word with dAddr[0]=1, long with dAddr[1:0]!=0, dSize=3, or dLoad and dStore both high. Response: 1-cycle dAlignErr pulse, no bus access, dHold low that cycle, stay IDLE.
REQ-010 An accepted request SHALL capture addr, data, size, regO; next state DREAD (load), DWRITE (long store), RMW_RD (byte/word store).
REQ-011 dHold SHALL be high whenever dLoad or dStore is high, the request is aligned, and state is not DONE.
REQ-012 extAddr SHALL equal captured address with bits [1:0] forced 0. extOE, extWR, extAddr SHALL be registered. extOE and extWR SHALL never be high together.
REQ-013 extData SHALL be driven only while extWR is high, else high-Z.
REQ-014 Each access state SHALL hold its strobe until extOK is sampled high, then advance on that edge.
REQ-015 DREAD exit SHALL go to DONE with dRegOutV=1 for one cycle and dRegOutO=captured regO. Byte lane SHALL be addr[1:0]*8 and word lane addr[1]*16, little-endian. Byte and word results SHALL be sign-extended to 32 bits.
REQ-016 RMW_RD SHALL read the long word. RMW_WR SHALL write it back with the addressed byte or word lane replaced by dWData low bits, then go to DONE.
REQ-017 DWRITE exit SHALL go to DONE. Stores SHALL never assert dRegOutV.
REQ-018 DONE SHALL last one cycle with dHold low, then go to IDLE unconditionally. A request present in DONE SHALL be evaluated in IDLE on the next cycle.
REQ-019 IFILL SHALL drive extAddr={iAddr[31:2],2'b00} with extOE high. On extOK it SHALL register iData and pulse iOK for one cycle, then return to IDLE.
REQ-020 Minimum load latency SHALL be: request cycle 0, extOE cycle 1, extOK cycle 1, dRegOutV and dHold low cycle 2.
REQ-021 Byte/word store SHALL take at least 4 cycles, with no other master between RMW_RD and RMW_WR.

Reset
REQ-022 reset low SHALL force IDLE immediately, independent of clock.
REQ-023 Reset SHALL clear to 0: extAddr, extOE, extWR, dHold, dRegOutV, dRegOutO, dRegOutVal, dAlignErr, iData, iOK, busErr, timeout counter. Reset SHALL release extData to high-Z.
REQ-024 Reset mid-access SHALL abandon the access without completion pulses.

Configuration
REQ-025 Macro MEM_ARB_TIMEOUT_EN, when defined, SHALL add an 8-bit counter cleared on entering any access state and incremented each cycle extOK is low.
REQ-026 When the counter reaches 255, the unit SHALL drop strobes and pulse busErr for one cycle, then:
- data access: go to DONE with dRegOutVal=0xFFFFFFFF and dRegOutV high for loads;
- fetch: pulse iOK with iData=0 and return to IDLE.
REQ-027 Without MEM_ARB_TIMEOUT_EN, accesses SHALL wait indefinitely and busErr SHALL be tied 0.

Verification
REQ-028 Load long dAddr=0x100, extOK same cycle, ext data 0x80FF7F01 -> dRegOutV cycle 2, dRegOutVal 0x80FF7F01, dHold high 2 cycles.
REQ-029 Load byte dAddr=0x103, data 0x80FF7F01 -> 0xFFFFFF80; load word dAddr=0x101 -> dAlignErr pulse, extOE stays 0.
REQ-030 Store byte 0xAB to 0x202, memory 0x11223344 -> read then write 0x11AB3344 on extData, dRegOutV never high.
REQ-031 iOE at 0x40 and dLoad 0x80 in same IDLE cycle -> data read first. After DONE, IFILL at 0x40; iOK pulses once.
REQ-032 Reset low during DREAD with extOE high -> extOE 0 at once, no dRegOutV. With MEM_ARB_TIMEOUT_EN and extOK held low, load -> busErr after 255 wait cycles, dRegOutVal 0xFFFFFFFF.

Source files
------------

// File: rtl/mem_arb_unit.sv
// mem_arb_unit: arbitrates EX data loads/stores and icache fills onto one external bus.
// Optional bus-wait timeout is compiled in when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    input  logic        dLoad,
    input  logic        dStore,
    input  logic [1:0]  dSize,
    input  logic [6:0]  dRegO,
    output logic        dHold,
    output logic [6:0]  dRegOutO,
    output logic [31:0] dRegOutVal,
    output logic        dRegOutV,
    output logic        dAlignErr,
    input  logic [31:0] iAddr,
    input  logic        iOE,
    output logic [31:0] iData,
    output logic        iOK,
    output logic [31:0] extAddr,
    inout  wire  [31:0] extData,
    output logic        extOE,
    output logic        extWR,
    input  logic        extOK,
    output logic        busErr
);

    // RMW_RD/RMW_WR form a locked read-modify-write for sub-long stores; DONE is the one-cycle release.
    typedef enum logic [2:0] {IDLE, DREAD, DWRITE, RMW_RD, RMW_WR, IFILL, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic [6:0]  rego_q, rego_d;
    logic [31:0] data_q, data_d;
    logic [31:0] ext_addr_q, ext_addr_d;
    logic        ext_oe_q, ext_oe_d;
    logic        ext_wr_q, ext_wr_d;
    logic [31:0] rval_q, rval_d;
    logic        rvalid_q, rvalid_d;
    logic [6:0]  rego_out_q, rego_out_d;
    logic [31:0] idata_q, idata_d;
    logic        iok_q, iok_d;
    logic        req, misalign, access, expired;
    logic        iaddr_unused;

    assign iaddr_unused = ^iAddr[1:0];

    assign req      = dLoad | dStore;
    assign misalign = (dSize == 2'd3) | ((dSize == 2'd1) & dAddr[0])
                    | ((dSize == 2'd2) & (|dAddr[1:0])) | (dLoad & dStore);
    assign access   = (state_q == DREAD) | (state_q == DWRITE) | (state_q == RMW_RD)
                    | (state_q == RMW_WR) | (state_q == IFILL);

    assign dHold     = reset & req & ~misalign & (state_q != DONE);
    assign dAlignErr = reset & req & misalign & (state_q != DONE);

    assign extAddr    = ext_addr_q;
    assign extOE      = ext_oe_q;
    assign extWR      = ext_wr_q;
    assign extData    = ext_wr_q ? data_q : 32'bz;
    assign dRegOutVal = rval_q;
    assign dRegOutV   = rvalid_q;
    assign dRegOutO   = rego_out_q;
    assign iData      = idata_q;
    assign iOK        = iok_q;

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                                 input logic [1:0] ln);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{ln, 3'b000} +: 8];
        h = ln[1] ? w[31:16] : w[15:0];
        case (sz)
            2'd0:    return {{24{b[7]}}, b};
            2'd1:    return {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] ln);
        logic [31:0] r;
        r = w;
        if (sz == 2'd0)
            r[{ln, 3'b000} +: 8] = wd[7:0];
        else if (ln[1])
            r[31:16] = wd[15:0];
        else
            r[15:0] = wd[15:0];
        return r;
    endfunction

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       bus_err_q;

    assign wait_cnt_d = (access && !extOK) ? wait_cnt_q + 8'd1 : 8'd0;
    assign expired    = access && !extOK && (wait_cnt_q == 8'hFF);
    assign busErr     = bus_err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= 8'd0;
            bus_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= expired;
        end
    end
`else
    assign expired = 1'b0;
    assign busErr  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        size_d     = size_q;
        rego_d     = rego_q;
        data_d     = data_q;
        ext_addr_d = ext_addr_q;
        ext_oe_d   = 1'b0;
        ext_wr_d   = 1'b0;
        rval_d     = rval_q;
        rvalid_d   = 1'b0;
        rego_out_d = rego_out_q;
        idata_d    = idata_q;
        iok_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && !misalign) begin
                    lane_d     = dAddr[1:0];
                    size_d     = dSize;
                    rego_d     = dRegO;
                    data_d     = dWData;
                    ext_addr_d = {dAddr[31:2], 2'b00};
                    if (dLoad) begin
                        state_d  = DREAD;
                        ext_oe_d = 1'b1;
                    end else if (dSize == 2'd2) begin
                        state_d  = DWRITE;
                        ext_wr_d = 1'b1;
                    end else begin
                        state_d  = RMW_RD;
                        ext_oe_d = 1'b1;
                    end
                // iok_q high means the fill just finished and iOE is still the stale request
                end else if (iOE && !iok_q) begin
                    state_d    = IFILL;
                    ext_addr_d = {iAddr[31:2], 2'b00};
                    ext_oe_d   = 1'b1;
                end
            end
            DREAD: begin
                if (extOK || expired) begin
                    rval_d     = extOK ? load_extract(extData, size_q, lane_q) : 32'hFFFF_FFFF;
                    rvalid_d   = 1'b1;
                    rego_out_d = rego_q;
                    state_d    = DONE;
                end else begin
                    ext_oe_d = 1'b1;
                end
            end
            RMW_RD: begin
                if (extOK) begin
                    data_d   = store_merge(extData, data_q, size_q, lane_q);
                    ext_wr_d = 1'b1;
                    state_d  = RMW_WR;
                end else if (expired) begin
                    state_d = DONE;
                end else begin
                    ext_oe_d = 1'b1;
                end
            end
            DWRITE, RMW_WR: begin
                if (extOK || expired)
                    state_d = DONE;
                else
                    ext_wr_d = 1'b1;
            end
            IFILL: begin
                if (extOK || expired) begin
                    idata_d = extOK ? extData : 32'd0;
                    iok_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    ext_oe_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            lane_q     <= 2'd0;
            size_q     <= 2'd0;
            rego_q     <= 7'd0;
            data_q     <= 32'd0;
            ext_addr_q <= 32'd0;
            ext_oe_q   <= 1'b0;
            ext_wr_q   <= 1'b0;
            rval_q     <= 32'd0;
            rvalid_q   <= 1'b0;
            rego_out_q <= 7'd0;
            idata_q    <= 32'd0;
            iok_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            rego_q     <= rego_d;
            data_q     <= data_d;
            ext_addr_q <= ext_addr_d;
            ext_oe_q   <= ext_oe_d;
            ext_wr_q   <= ext_wr_d;
            rval_q     <= rval_d;
            rvalid_q   <= rvalid_d;
            rego_out_q <= rego_out_d;
            idata_q    <= idata_d;
            iok_q      <= iok_d;
        end
    end

endmodule

// File: tb/tb_mem_arb_unit.sv
// Bench for mem_arb_unit: randomized bus responder plus a word-level memory reference model.
`timescale 1ns/1ps
module tb_mem_arb_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dAddr = '0, dWData = '0, iAddr = '0;
    logic        dLoad = 1'b0, dStore = 1'b0, iOE = 1'b0, extOK = 1'b0;
    logic [1:0]  dSize = '0;
    logic [6:0]  dRegO = '0;
    wire         dHold, dRegOutV, dAlignErr, iOK, extOE, extWR, busErr;
    wire  [6:0]  dRegOutO;
    wire  [31:0] dRegOutVal, iData, extAddr, extData;
    logic [31:0] drv_data = '0;
    logic        drv_en = 1'b0;

    assign extData = drv_en ? drv_data : 32'bz;

    mem_arb_unit dut (
        .clock(clock), .reset(reset),
        .dAddr(dAddr), .dWData(dWData), .dLoad(dLoad), .dStore(dStore), .dSize(dSize), .dRegO(dRegO),
        .dHold(dHold), .dRegOutO(dRegOutO), .dRegOutVal(dRegOutVal), .dRegOutV(dRegOutV),
        .dAlignErr(dAlignErr), .iAddr(iAddr), .iOE(iOE), .iData(iData), .iOK(iOK),
        .extAddr(extAddr), .extData(extData), .extOE(extOE), .extWR(extWR), .extOK(extOK),
        .busErr(busErr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    int   n_cmp = 0, n_fail = 0;
    int   vcount = 0, okcount = 0, errcount = 0, strobe_cyc = 0, both_cnt = 0, lowbit_cnt = 0;
    int   min_wait = 0, max_wait = 0, wait_left = 0;
    logic no_ack = 1'b0, in_beat = 1'b0;
    acc_t log_q[$];
    acc_t resp_e;
    logic [31:0] bus_mem   [logic [29:0]];
    logic [31:0] model_mem [logic [29:0]];

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({w[15:0], w[15:0]} * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [29:0] w);
        return bus_mem.exists(w) ? bus_mem[w] : init_word(w);
    endfunction

    function automatic logic [31:0] model_rd(input logic [29:0] w);
        return model_mem.exists(w) ? model_mem[w] : init_word(w);
    endfunction

    // External memory: random wait states, acks by raising extOK for one cycle.
    always @(negedge clock) begin
        if (!reset) begin
            extOK = 1'b0; drv_en = 1'b0; in_beat = 1'b0;
        end else if (extOK) begin
            extOK = 1'b0; drv_en = 1'b0; in_beat = 1'b0;
        end else if (extOE || extWR) begin
            if (!in_beat) begin
                in_beat   = 1'b1;
                wait_left = $urandom_range(min_wait, max_wait);
            end
            if (!no_ack) begin
                if (wait_left == 0) begin
                    extOK       = 1'b1;
                    resp_e.wr   = extWR;
                    resp_e.addr = extAddr;
                    if (extWR) begin
                        bus_mem[extAddr[31:2]] = extData;
                        resp_e.data = extData;
                    end else begin
                        drv_data    = bus_rd(extAddr[31:2]);
                        drv_en      = 1'b1;
                        resp_e.data = drv_data;
                    end
                    log_q.push_back(resp_e);
                end else begin
                    wait_left--;
                end
            end
        end else begin
            in_beat = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (dRegOutV) vcount++;
        if (iOK) okcount++;
        if (busErr) errcount++;
        if (extOE || extWR) strobe_cyc++;
        if (extOE && extWR) both_cnt++;
        if ((extOE || extWR) && extAddr[1:0] != 2'b00) lowbit_cnt++;
    end

    task automatic run_data(input logic ld, input logic st, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd, input logic [6:0] ro,
                            output int hc, output logic to, output logic ae, output logic v,
                            output logic [31:0] val, output logic [6:0] ro_o, output int vs);
        int v0;
        v0 = vcount; hc = 0; to = 1'b1; ae = 1'b0; v = 1'b0; val = '0; ro_o = '0;
        @(posedge clock); #1;
        dLoad = ld; dStore = st; dSize = sz; dAddr = a; dWData = wd; dRegO = ro;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (dHold) hc++;
            else begin
                ae = dAlignErr; v = dRegOutV; val = dRegOutVal; ro_o = dRegOutO; to = 1'b0;
                break;
            end
        end
        @(posedge clock); #1;
        dLoad = 1'b0; dStore = 1'b0;
        @(negedge clock); #1;
        vs = vcount - v0;
    endtask

    task automatic test_reset();
        dLoad = 1'b1; dAddr = 32'h100; dSize = 2'd2; iOE = 1'b1; iAddr = 32'h44;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++; if (dHold !== 1'b0) begin n_fail++; $display("FAIL reset_dHold: got %b want 0", dHold); end
        n_cmp++; if ({extOE, extWR, extAddr} !== 34'd0) begin n_fail++; $display("FAIL reset_ext: got oe=%b wr=%b addr=%h want 0", extOE, extWR, extAddr); end
        n_cmp++; if ({dRegOutV, dRegOutO, dRegOutVal, dAlignErr} !== 41'd0) begin n_fail++; $display("FAIL reset_dout: got v=%b o=%h val=%h ae=%b want 0", dRegOutV, dRegOutO, dRegOutVal, dAlignErr); end
        n_cmp++; if ({iOK, iData, busErr} !== 34'd0) begin n_fail++; $display("FAIL reset_iside: got ok=%b data=%h berr=%b want 0", iOK, iData, busErr); end
        dLoad = 1'b0; iOE = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_load_long();
        int hc, vs; logic to, ae, v; logic [31:0] val; logic [6:0] ro;
        min_wait = 0; max_wait = 0;
        bus_mem[30'h40] = 32'h80FF_7F01; model_mem[30'h40] = 32'h80FF_7F01;
        run_data(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 7'h15, hc, to, ae, v, val, ro, vs);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL ldl_timeout: got %b want 0", to); end
        n_cmp++; if (hc != 2) begin n_fail++; $display("FAIL ldl_hold_cycles: got %0d want 2", hc); end
        n_cmp++; if (v !== 1'b1 || val !== 32'h80FF_7F01) begin n_fail++; $display("FAIL ldl_value: got v=%b %h want 1 80ff7f01", v, val); end
        n_cmp++; if (ro !== 7'h15) begin n_fail++; $display("FAIL ldl_regout: got %h want 15", ro); end
        n_cmp++; if (vs != 1) begin n_fail++; $display("FAIL ldl_vpulses: got %0d want 1", vs); end
    endtask

    task automatic test_load_lanes();
        int hc, vs; logic to, ae, v; logic [31:0] val, a, exp; logic [6:0] ro; logic [1:0] sz;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin a = 32'h103; sz = 2'd0; exp = 32'hFFFF_FF80; end
                1:       begin a = 32'h101; sz = 2'd0; exp = 32'h0000_007F; end
                default: begin a = 32'h102; sz = 2'd1; exp = 32'hFFFF_80FF; end
            endcase
            run_data(1'b1, 1'b0, sz, a, 32'h0, 7'(k + 1), hc, to, ae, v, val, ro, vs);
            n_cmp++; if (to !== 1'b0 || v !== 1'b1 || val !== exp) begin n_fail++; $display("FAIL lane_load_%0d: got to=%b v=%b %h want %h", k, to, v, val, exp); end
        end
    endtask

    task automatic test_misaligned();
        int hc, vs, s0, l0; logic to, ae, v; logic [31:0] val, a; logic [6:0] ro; logic ld, st; logic [1:0] sz;
        for (int k = 0; k < 5; k++) begin
            case (k)
                0:       begin ld = 1; st = 0; sz = 2'd1; a = 32'h101; end
                1:       begin ld = 1; st = 0; sz = 2'd2; a = 32'h102; end
                2:       begin ld = 1; st = 0; sz = 2'd3; a = 32'h100; end
                3:       begin ld = 1; st = 1; sz = 2'd2; a = 32'h100; end
                default: begin ld = 0; st = 1; sz = 2'd1; a = 32'h103; end
            endcase
            s0 = strobe_cyc; l0 = log_q.size();
            run_data(ld, st, sz, a, 32'h1234, 7'h2, hc, to, ae, v, val, ro, vs);
            n_cmp++; if (to !== 1'b0 || ae !== 1'b1 || hc != 0) begin n_fail++; $display("FAIL misalign_%0d: got to=%b err=%b hold=%0d want 0 1 0", k, to, ae, hc); end
            n_cmp++; if (strobe_cyc != s0 || log_q.size() != l0 || vs != 0) begin n_fail++; $display("FAIL misalign_bus_%0d: got strobes=%0d v=%0d want 0 0", k, strobe_cyc - s0, vs); end
        end
    endtask

    task automatic test_store_byte();
        int hc, vs; logic to, ae, v; logic [31:0] val; logic [6:0] ro;
        bus_mem[30'h80] = 32'h1122_3344; model_mem[30'h80] = 32'h1122_3344;
        log_q.delete();
        run_data(1'b0, 1'b1, 2'd0, 32'h202, 32'h0000_00AB, 7'h7, hc, to, ae, v, val, ro, vs);
        n_cmp++; if (to !== 1'b0 || hc < 3) begin n_fail++; $display("FAIL stb_cycles: got to=%b hold=%0d want 0 >=3", to, hc); end
        n_cmp++; if (vs != 0) begin n_fail++; $display("FAIL stb_no_v: got %0d want 0", vs); end
        n_cmp++; if (log_q.size() != 2) begin n_fail++; $display("FAIL stb_beats: got %0d want 2", log_q.size()); end
        else begin
            n_cmp++; if (log_q[0].wr !== 1'b0 || log_q[0].addr !== 32'h200) begin n_fail++; $display("FAIL stb_read: got wr=%b %h want 0 200", log_q[0].wr, log_q[0].addr); end
            n_cmp++; if (log_q[1].wr !== 1'b1 || log_q[1].addr !== 32'h200 || log_q[1].data !== 32'h11AB_3344) begin n_fail++; $display("FAIL stb_write: got wr=%b %h %h want 1 200 11ab3344", log_q[1].wr, log_q[1].addr, log_q[1].data); end
        end
        model_mem[30'h80] = 32'h11AB_3344;
    endtask

    task automatic test_priority();
        int ok0, budget; logic got;
        min_wait = 0; max_wait = 2;
        log_q.delete(); ok0 = okcount;
        @(posedge clock); #1;
        iOE = 1'b1; iAddr = 32'h40; dLoad = 1'b1; dAddr = 32'h80; dSize = 2'd2; dRegO = 7'h3;
        budget = 0;
        do begin @(negedge clock); budget++; end while (dHold && budget < 200);
        @(posedge clock); #1; dLoad = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin @(negedge clock); got = iOK; end
        @(posedge clock); #1; iOE = 1'b0;
        repeat (4) @(negedge clock); #1;
        n_cmp++; if (!got || budget >= 200) begin n_fail++; $display("FAIL prio_done: got ifill=%b dcycles=%0d want 1 <200", got, budget); end
        n_cmp++; if (okcount - ok0 != 1) begin n_fail++; $display("FAIL prio_iok_pulses: got %0d want 1", okcount - ok0); end
        n_cmp++; if (log_q.size() != 2) begin n_fail++; $display("FAIL prio_beats: got %0d want 2", log_q.size()); end
        else begin
            n_cmp++; if (log_q[0].addr !== 32'h80 || log_q[1].addr !== 32'h40 || log_q[1].wr !== 1'b0) begin n_fail++; $display("FAIL prio_order: got %h then %h want 80 then 40", log_q[0].addr, log_q[1].addr); end
        end
        n_cmp++; if (iData !== bus_rd(30'h10)) begin n_fail++; $display("FAIL prio_idata: got %h want %h", iData, bus_rd(30'h10)); end
    endtask

    task automatic test_reset_mid();
        int v0, l0; logic seen;
        min_wait = 20; max_wait = 20;
        @(posedge clock); #1;
        dLoad = 1'b1; dAddr = 32'h300; dSize = 2'd2; dRegO = 7'h11;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin @(negedge clock); seen = extOE; end
        v0 = vcount; l0 = log_q.size();
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (!seen || extOE !== 1'b0) begin n_fail++; $display("FAIL rstmid_oe: got seen=%b oe=%b want 1 0", seen, extOE); end
        n_cmp++; if (dHold !== 1'b0 || extAddr !== 32'h0) begin n_fail++; $display("FAIL rstmid_clear: got hold=%b addr=%h want 0 0", dHold, extAddr); end
        repeat (2) @(negedge clock);
        dLoad = 1'b0;
        reset = 1'b1;
        repeat (30) @(negedge clock); #1;
        n_cmp++; if (vcount != v0 || log_q.size() != l0 || extOE !== 1'b0) begin n_fail++; $display("FAIL rstmid_abandon: got v=%0d beats=%0d oe=%b want 0 0 0", vcount - v0, log_q.size() - l0, extOE); end
        min_wait = 0; max_wait = 3;
    endtask

    task automatic test_random();
        int hc, vs, sh, s0; logic to, ae, v, ld, st, mis; logic [31:0] val, a, wd, w, exp, mask;
        logic [6:0] ro, rgo; logic [1:0] sz;
        min_wait = 0; max_wait = 3;
        for (int n = 0; n < 80; n++) begin
            a   = 32'h1000 + 32'($urandom_range(0, 63));
            sz  = 2'($urandom_range(0, 3));
            wd  = $urandom;
            rgo = 7'($urandom);
            if ($urandom_range(0, 9) == 0) begin ld = 1; st = 1; end
            else begin ld = 1'($urandom_range(0, 1)); st = !ld; end
            mis = (sz == 3) || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0) || (ld && st);
            s0  = strobe_cyc;
            run_data(ld, st, sz, a, wd, rgo, hc, to, ae, v, val, ro, vs);
            n_cmp++; if (to !== 1'b0 || ae !== mis) begin n_fail++; $display("FAIL rnd_%0d_accept: got to=%b err=%b want 0 %b", n, to, ae, mis); end
            sh = int'(a[1:0]) * 8;
            w  = model_rd(a[31:2]);
            if (mis) begin
                n_cmp++; if (strobe_cyc != s0) begin n_fail++; $display("FAIL rnd_%0d_nobus: got %0d strobes want 0", n, strobe_cyc - s0); end
            end else if (ld) begin
                exp = w >> sh;
                if (sz == 0) begin exp = exp & 32'hFF;   if (exp >= 32'h80)   exp = exp - 32'h100; end
                if (sz == 1) begin exp = exp & 32'hFFFF; if (exp >= 32'h8000) exp = exp - 32'h1_0000; end
                n_cmp++; if (v !== 1'b1 || val !== exp || ro !== rgo || vs != 1) begin n_fail++; $display("FAIL rnd_%0d_load: got v=%b %h r=%h n=%0d want %h r=%h", n, v, val, ro, vs, exp, rgo); end
            end else begin
                mask = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
                mask = mask << sh;
                model_mem[a[31:2]] = (w & ~mask) | ((wd << sh) & mask);
                n_cmp++; if (vs != 0) begin n_fail++; $display("FAIL rnd_%0d_store_v: got %0d want 0", n, vs); end
            end
        end
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (bus_rd(30'h400 + 30'(k)) !== model_rd(30'h400 + 30'(k))) begin
                n_fail++; $display("FAIL rnd_mem_%0d: got %h want %h", k, bus_rd(30'h400 + 30'(k)), model_rd(30'h400 + 30'(k)));
            end
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int hc, vs, e0; logic to, ae, v; logic [31:0] val; logic [6:0] ro;
        e0 = errcount; no_ack = 1'b1;
        run_data(1'b1, 1'b0, 2'd2, 32'h500, 32'h0, 7'h9, hc, to, ae, v, val, ro, vs);
        no_ack = 1'b0;
        n_cmp++; if (to !== 1'b0 || v !== 1'b1 || val !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL tmo_load: got to=%b v=%b %h want 0 1 ffffffff", to, v, val); end
        n_cmp++; if (hc < 256 || hc > 258) begin n_fail++; $display("FAIL tmo_wait: got %0d hold cycles want 256..258", hc); end
        n_cmp++; if (errcount - e0 != 1) begin n_fail++; $display("FAIL tmo_buserr: got %0d pulses want 1", errcount - e0); end
    endtask
`endif

    task automatic test_bus_rules();
        n_cmp++; if (both_cnt != 0) begin n_fail++; $display("FAIL rule_oe_wr: got %0d overlap cycles want 0", both_cnt); end
        n_cmp++; if (lowbit_cnt != 0) begin n_fail++; $display("FAIL rule_addr_lsb: got %0d cycles want 0", lowbit_cnt); end
`ifndef MEM_ARB_TIMEOUT_EN
        n_cmp++; if (errcount != 0) begin n_fail++; $display("FAIL rule_buserr_tied: got %0d pulses want 0", errcount); end
`endif
    endtask

    initial begin
        #3 reset = 1'b0;
        test_reset();
        test_load_long();
        test_load_lanes();
        test_misaligned();
        test_store_byte();
        test_priority();
        test_reset_mid();
        test_random();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_bus_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
